program_loader: RTL



---
 rtl/mips_loader_pkg.sv | 25 ++
 rtl/program_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mips_loader_pkg.sv
// -----------------------------------------------------------------------------
// Module : mips_loader_pkg
// Brief  : Shared types and constants for the program loader.
// Rev    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         LEN_W     = 16;

endpackage

`default_nettype wire

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// Module : program_loader
// Brief  : Framed byte-stream loader that fills program memory and holds the
//          core in reset until a load completes with a good checksum.
// Rev    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module program_loader
    import mips_loader_pkg::*;
#(
    parameter int          MEMORY_DEPTH   = 512,
    parameter logic [31:0] BASE_ADDR      = 32'h0040_0000,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter bit          BOOT_HOLD      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [31:0] c_DEPTH        = 32'(MEMORY_DEPTH);
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    loader_state_t      r_state;
    loader_state_t      w_next;
    logic [LEN_W-1:0]   r_count;
    logic [LEN_W-1:0]   r_word_idx;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_asm;
    logic [7:0]         r_sum;
    logic [31:0]        r_timer;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_hold;
    logic               r_done;
    logic               r_error;

    logic               w_accept;
    logic               w_timed;
    logic               w_timeout;
    logic [LEN_W-1:0]   w_len;
    logic               w_last_byte;
    logic               w_last_word;

    // The only stall is the write cycle, so a byte can never be taken then.
    assign byte_ready  = ~r_we;
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign cpu_hold    = r_hold;
    assign load_done   = r_done;
    assign load_error  = r_error;

    assign w_accept    = byte_valid & byte_ready;
    assign w_timed     = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                         (r_state == DATA)   || (r_state == CHECK);
    assign w_timeout   = w_timed & ~w_accept & (r_timer == c_TIMEOUT_LAST);
    assign w_len       = {r_count[15:8], byte_data};
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_last_word = (r_word_idx == r_count - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = ERROR;
        end else if (w_accept) begin
            case (r_state)
                IDLE, DONE, ERROR: if (byte_data == SYNC_BYTE) w_next = LEN_HI;
                LEN_HI:            w_next = LEN_LO;
                LEN_LO: begin
                    if (32'(w_len) > c_DEPTH)    w_next = ERROR;
                    else if (w_len == 16'd0)     w_next = CHECK;
                    else                         w_next = DATA;
                end
                DATA:  if (w_last_byte && w_last_word) w_next = CHECK;
                CHECK: w_next = (byte_data == r_sum) ? DONE : ERROR;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_sum      <= '0;
            r_timer    <= '0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= '0;
            r_hold     <= BOOT_HOLD;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_we <= 1'b0;

            if (w_timed && !w_accept && !w_timeout) r_timer <= r_timer + 32'd1;
            else                                    r_timer <= '0;

            if (w_accept) begin
                case (r_state)
                    LEN_HI: r_count[15:8] <= byte_data;
                    LEN_LO: begin
                        r_count[7:0] <= byte_data;
                        r_word_idx   <= '0;
                        r_byte_cnt   <= '0;
                        r_sum        <= '0;
                    end
                    DATA: begin
                        r_asm      <= {r_asm[15:0], byte_data};
                        r_sum      <= r_sum + byte_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            r_we    <= 1'b1;
                            r_addr  <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                            r_wdata <= {r_asm, byte_data};
                            if (!w_last_word) r_word_idx <= r_word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end

            // Status flags change only on entry to the states that own them.
            if (w_next != r_state) begin
                case (w_next)
                    LEN_HI: begin
                        r_hold  <= 1'b1;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end
                    DONE: begin
                        r_hold <= 1'b0;
                        r_done <= 1'b1;
                    end
                    ERROR: begin
                        r_hold  <= 1'b1;
                        r_error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
